// File: rtl/cat_motion_ctl.sv
// Frame-rate motion controller for a walking/jumping cat sprite, updated once per vblank rising edge.
// Optional build macro CAT_WRAP_EN: horizontal motion wraps around the screen instead of saturating.
module cat_motion_ctl #(
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600,
    parameter int SPRITE_W = 48,
    parameter int SPRITE_H = 64,
    parameter int STEP     = 4,
    parameter int JUMP_V0  = 16,
    parameter int VMAX     = 16
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        vblnk_in,
    input  logic        start,
    input  logic        left,
    input  logic        right,
    input  logic        jump,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        frame_tick,
    output logic        airborne
);

    localparam logic signed [12:0] XMAX_S   = 13'(SCREEN_W - SPRITE_W);
    localparam logic signed [12:0] GROUND_S = 13'(SCREEN_H - SPRITE_H);
    localparam logic signed [12:0] STEP_S   = 13'(STEP);
    localparam logic        [11:0] X0       = 12'((SCREEN_W - SPRITE_W) / 2);
    localparam logic        [11:0] GROUND_Y = 12'(SCREEN_H - SPRITE_H);
    localparam logic        [4:0]  V0       = 5'(JUMP_V0);
    localparam logic        [4:0]  VMAX_V   = 5'(VMAX);

    typedef enum logic [1:0] {IDLE, GROUND, RISE, FALL} state_t;

    state_t             state_reg, state_next;
    logic        [11:0] x_next, y_next, x_moved;
    logic        [4:0]  vel_reg, vel_next, vel_inc;
    logic               vblnk_reg;
    logic               tick;
    logic               airborne_next;
    logic signed [12:0] x_calc, y_calc;

    // Edge detector runs every cycle, independent of the FSM update.
    assign tick = vblnk_in & ~vblnk_reg;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            xpos       <= X0;
            ypos       <= GROUND_Y;
            vel_reg    <= '0;
            frame_tick <= 1'b0;
            airborne   <= 1'b0;
            vblnk_reg  <= 1'b0;
        end else begin
            vblnk_reg  <= vblnk_in;
            frame_tick <= tick;
            if (tick) begin
                state_reg <= state_next;
                xpos      <= x_next;
                ypos      <= y_next;
                vel_reg   <= vel_next;
                airborne  <= airborne_next;
            end
        end
    end

    // Candidate horizontal position for any non-idle state.
    always_comb begin
        x_calc = $signed({1'b0, xpos});
        if (left && !right)
            x_calc = x_calc - STEP_S;
        else if (right && !left)
            x_calc = x_calc + STEP_S;
`ifdef CAT_WRAP_EN
        if (x_calc < 0)
            x_moved = 12'(x_calc + XMAX_S + 13'sd1);
        else if (x_calc > XMAX_S)
            x_moved = 12'(x_calc - XMAX_S - 13'sd1);
        else
            x_moved = 12'(x_calc);
`else
        if (x_calc < 0)
            x_moved = 12'd0;
        else if (x_calc > XMAX_S)
            x_moved = 12'(XMAX_S);
        else
            x_moved = 12'(x_calc);
`endif
    end

    always_comb begin
        state_next = state_reg;
        x_next     = xpos;
        y_next     = ypos;
        vel_next   = vel_reg;
        y_calc     = $signed({1'b0, ypos});
        vel_inc    = (vel_reg >= VMAX_V) ? VMAX_V : vel_reg + 5'd1;
        case (state_reg)
            IDLE: begin
                x_next   = X0;
                y_next   = GROUND_Y;
                vel_next = '0;
                if (start)
                    state_next = GROUND;
            end
            GROUND: begin
                x_next = x_moved;
                if (jump) begin
                    state_next = RISE;
                    vel_next   = V0;
                end
            end
            RISE: begin
                x_next = x_moved;
                y_calc = $signed({1'b0, ypos}) - $signed({8'b0, vel_reg});
                if (y_calc <= 0) begin
                    y_next     = '0;
                    vel_next   = '0;
                    state_next = FALL;
                end else begin
                    y_next   = 12'(y_calc);
                    vel_next = vel_reg - 5'd1;
                    if (vel_reg <= 5'd1)
                        state_next = FALL;
                end
            end
            FALL: begin
                x_next   = x_moved;
                vel_next = vel_inc;
                y_calc   = $signed({1'b0, ypos}) + $signed({8'b0, vel_inc});
                if (y_calc >= GROUND_S) begin
                    y_next     = GROUND_Y;
                    vel_next   = '0;
                    state_next = GROUND;
                end else begin
                    y_next = 12'(y_calc);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        airborne_next = (state_next == RISE) || (state_next == FALL);
    end

endmodule
